// File: rtl/mem_access_pkg.sv
// Shared types and constants for the memory access unit.
package mem_access_pkg;

  localparam int unsigned LAT_W   = 4;
  localparam int unsigned LAT_MAX = (1 << LAT_W) - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2
  } state_t;

  // True when a latency value fits the down-counter and is at least one cycle.
  function automatic bit lat_ok(input int unsigned lat);
    return (lat >= 1) && (lat <= LAT_MAX);
  endfunction

  // True when the whole parameter set is usable (address must fit inside the bus).
  function automatic bit params_ok(input int unsigned dw, input int unsigned aw,
                                   input int unsigned rd_lat, input int unsigned wr_lat);
    return (aw >= 1) && (dw >= aw) && lat_ok(rd_lat) && lat_ok(wr_lat);
  endfunction

endpackage

// File: rtl/mau_ram.sv
// Single-port synchronous word array: registered write, registered read of a combinational address.
module mau_ram
  import mem_access_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DW-1:0] mem [DEPTH];

  // Contents survive reset; the read port samples every cycle.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_access_unit.sv
// MAR/MDR plus internal memory with configurable read/write latency and start/busy/done handshake.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned DW     = 32,
  parameter int unsigned AW     = 9,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned WR_LAT = 1
) (
  input  logic          clk,
  input  logic          clr,
  input  logic [DW-1:0] bus_in,
  input  logic          mar_in,
  input  logic          mdr_in,
  input  logic          mem_rd,
  input  logic          mem_wr,
  output logic [AW-1:0] mar_q,
  output logic [DW-1:0] mdr_q,
  output logic          busy,
  output logic          done,
  output logic          err
);

  if (!params_ok(DW, AW, RD_LAT, WR_LAT)) begin : g_bad_params
    $error("mem_access_unit: illegal parameters (need 1<=AW<=DW, 1<=RD_LAT,WR_LAT<=15)");
  end

  localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(RD_LAT - 1);
  localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WR_LAT - 1);

  state_t         state;
  logic [LAT_W-1:0] cnt;

  logic          idle_c;
  logic          last_c;
  logic          illegal_c;
  logic [AW-1:0] req_addr_c;
  logic [AW-1:0] ram_addr_c;
  logic          ram_we_c;
  logic [DW-1:0] ram_rdata;

  // Request decode; in IDLE a same-cycle MAR load is bypassed straight to the RAM address.
  always_comb begin
    idle_c     = (state == IDLE);
    last_c     = (cnt == '0);
    req_addr_c = mar_in ? bus_in[AW-1:0] : mar_q;
    ram_addr_c = idle_c ? req_addr_c : mar_q;
    ram_we_c   = (state == WR_WAIT) && last_c;
    if (idle_c) begin
      illegal_c = mem_rd && mem_wr;
    end else begin
      illegal_c = mem_rd || mem_wr || mar_in || mdr_in;
    end
  end

  // MAR/MDR stay locked while busy, so they double as the latched address and write data.
  mau_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we_c),
    .addr (ram_addr_c),
    .wdata(mdr_q),
    .rdata(ram_rdata)
  );

  // Transaction FSM, latency counter, MAR/MDR and status pulses.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt   <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= illegal_c;
      case (state)
        IDLE: begin
          if (!illegal_c) begin
            if (mar_in) mar_q <= bus_in[AW-1:0];
            if (mdr_in) mdr_q <= bus_in;
            if (mem_rd) begin
              state <= RD_WAIT;
              cnt   <= RD_LOAD;
              busy  <= 1'b1;
            end else if (mem_wr) begin
              state <= WR_WAIT;
              cnt   <= WR_LOAD;
              busy  <= 1'b1;
            end
          end
        end
        RD_WAIT: begin
          if (last_c) begin
            mdr_q <= ram_rdata;
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        WR_WAIT: begin
          if (last_c) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - LAT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
